// File: rtl/decode_pkg.sv
// Shared opcodes, control enums and the decoded control bundle for the RV32I decode stage.
// RV32M_EN adds the multiply/divide ALU codes 16-23.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4} imm_sel_e;

  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} mem_to_reg_e;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3, ALU_SLTU = 5'd4,
    ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7, ALU_OR = 5'd8, ALU_AND = 5'd9,
    ALU_PASS_B = 5'd15,
    ALU_MUL = 5'd16, ALU_MULH = 5'd17, ALU_MULHSU = 5'd18, ALU_MULHU = 5'd19,
    ALU_DIV = 5'd20, ALU_DIVU = 5'd21, ALU_REM = 5'd22, ALU_REMU = 5'd23
  } alu_op_e;

  typedef struct packed {
    logic        reg_write;
    logic        operand_a;
    logic        operand_b;
    logic        load;
    logic        store;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        mem_en;
    imm_sel_e    imm_sel;
    mem_to_reg_e mem_to_reg;
    alu_op_e     alu_control;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  fun3;
    logic        illegal;
  } ctrl_bundle_t;

endpackage

// File: rtl/decode_ctrl_stage_if.sv
// Fetch-side and execute-side handshake plus the control bundle of the decode stage.
// master is the surrounding pipeline (fetch + execute), slave is the decode stage.
interface decode_ctrl_stage_if #(parameter int ALU_OP_W = 5);
  logic                if_valid;
  logic                if_ready;
  logic [31:0]         if_instr;
  logic                ex_valid;
  logic                ex_ready;
  logic                reg_write, operand_a, operand_b, load, store, branch, jal, jalr, mem_en;
  logic [2:0]          imm_sel;
  logic [1:0]          mem_to_reg;
  logic [ALU_OP_W-1:0] alu_control;
  logic [4:0]          rs1, rs2, rd;
  logic [2:0]          fun3;
  logic                illegal;

  modport master (
    output if_valid, if_instr, ex_ready,
    input  if_ready, ex_valid, reg_write, operand_a, operand_b, load, store, branch, jal, jalr,
           mem_en, imm_sel, mem_to_reg, alu_control, rs1, rs2, rd, fun3, illegal
  );

  modport slave (
    input  if_valid, if_instr, ex_ready,
    output if_ready, ex_valid, reg_write, operand_a, operand_b, load, store, branch, jal, jalr,
           mem_en, imm_sel, mem_to_reg, alu_control, rs1, rs2, rd, fun3, illegal
  );
endinterface

// File: rtl/ctrl_decode.sv
// Purely combinational RV32I instruction -> control bundle decode, plus source-register usage.
// RV32M_EN enables decoding of the funct7=0000001 multiply/divide group.
module ctrl_decode
  import decode_pkg::*;
(
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl,
  output logic         use_rs1,
  output logic         use_rs2
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] f3;
  alu_op_e    base_op;
  logic       bad;

  assign opcode = instr[6:0];
  assign funct7 = instr[31:25];
  assign f3     = instr[14:12];

  always_comb begin
    case (f3)
      3'd0:    base_op = ALU_ADD;
      3'd1:    base_op = ALU_SLL;
      3'd2:    base_op = ALU_SLT;
      3'd3:    base_op = ALU_SLTU;
      3'd4:    base_op = ALU_XOR;
      3'd5:    base_op = ALU_SRL;
      3'd6:    base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  end

  always_comb begin
    ctrl    = '0;
    bad     = 1'b0;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        use_rs2        = 1'b1;
        if (funct7 == 7'b0000001) begin
`ifdef RV32M_EN
          ctrl.alu_control = alu_op_e'({2'b10, f3});
`else
          bad = 1'b1;
`endif
        end else if (f3 == 3'd0 && instr[30]) begin
          ctrl.alu_control = ALU_SUB;
        end else if (f3 == 3'd5 && instr[30]) begin
          ctrl.alu_control = ALU_SRA;
        end else begin
          ctrl.alu_control = base_op;
        end
      end
      OP_IMM: begin
        ctrl.reg_write   = 1'b1;
        ctrl.operand_b   = 1'b1;
        ctrl.alu_control = (f3 == 3'd5 && instr[30]) ? ALU_SRA : base_op;
        // Shift immediates reuse funct7 as an encoding field; only 0x00/0x20 exist.
        if ((f3 == 3'd1 || f3 == 3'd5) && funct7 != 7'h00 && funct7 != 7'h20) bad = 1'b1;
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.operand_b  = 1'b1;
        ctrl.load       = 1'b1;
        ctrl.mem_to_reg = WB_MEM;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) bad = 1'b1;
      end
      OP_STORE: begin
        ctrl.operand_b = 1'b1;
        ctrl.store     = 1'b1;
        ctrl.mem_en    = 1'b1;
        ctrl.imm_sel   = IMM_S;
        use_rs2        = 1'b1;
        if (f3 > 3'd2) bad = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.operand_a = 1'b1;
        ctrl.operand_b = 1'b1;
        ctrl.branch    = 1'b1;
        ctrl.imm_sel   = IMM_B;
        use_rs2        = 1'b1;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.operand_a  = 1'b1;
        ctrl.operand_b  = 1'b1;
        ctrl.jal        = 1'b1;
        ctrl.imm_sel    = IMM_J;
        ctrl.mem_to_reg = WB_PC4;
        use_rs1         = 1'b0;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.operand_b  = 1'b1;
        ctrl.jalr       = 1'b1;
        ctrl.mem_to_reg = WB_PC4;
      end
      OP_LUI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.operand_b   = 1'b1;
        ctrl.imm_sel     = IMM_U;
        ctrl.alu_control = ALU_PASS_B;
        use_rs1          = 1'b0;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.operand_a = 1'b1;
        ctrl.operand_b = 1'b1;
        ctrl.imm_sel   = IMM_U;
        use_rs1        = 1'b0;
      end
      default: bad = 1'b1;
    endcase
    // An illegal instruction still issues, but as an inert bundle carrying only its fields.
    if (bad) ctrl = '0;
    ctrl.illegal = bad;
    ctrl.rs1     = instr[19:15];
    ctrl.rs2     = instr[24:20];
    ctrl.rd      = instr[11:7];
    ctrl.fun3    = f3;
    if (ctrl.rd == 5'd0) ctrl.reg_write = 1'b0;
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered RV32I decode stage: handshake, output register, flush and load-use interlock.
// Optional RV32M_EN (see ctrl_decode) requires ALU_OP_W >= 5.
module decode_ctrl_stage
  import decode_pkg::*;
#(
  parameter int ALU_OP_W          = 5,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input logic              clk,
  input logic              rst_n,
  input logic              flush,
  decode_ctrl_stage_if.slave bus
);

  typedef enum logic {RUN, STALL} state_e;

  localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES);

  ctrl_bundle_t dec;
  ctrl_bundle_t bundle_q;
  logic         use_rs1, use_rs2;
  state_e       state;
  logic [1:0]   age;
  logic [4:0]   load_rd;
  logic         ex_valid_q;
  logic         advance, hazard, accept;

  ctrl_decode u_decode (
    .instr   (bus.if_instr),
    .ctrl    (dec),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  assign advance = !ex_valid_q || bus.ex_ready;
  assign hazard  = (age != 2'd0) && bus.if_valid && (load_rd != 5'd0) &&
                   ((use_rs1 && dec.rs1 == load_rd) || (use_rs2 && dec.rs2 == load_rd));
  assign bus.if_ready = advance && !hazard && !flush;
  assign accept       = bus.if_valid && bus.if_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      age        <= 2'd0;
      load_rd    <= 5'd0;
      ex_valid_q <= 1'b0;
      bundle_q   <= '0;
    end else if (flush) begin
      state      <= RUN;
      age        <= 2'd0;
      ex_valid_q <= 1'b0;
      bundle_q   <= '0;
    end else begin
      if (accept) begin
        ex_valid_q <= 1'b1;
        bundle_q   <= dec;
      end else if (advance) begin
        ex_valid_q <= 1'b0;
        bundle_q   <= '0;
      end
      // A newly accepted load restarts the window even if an older one is still counting.
      if (accept && dec.load && dec.rd != 5'd0) begin
        load_rd <= dec.rd;
        age     <= STALL_INIT;
      end else if (advance && age != 2'd0) begin
        age <= age - 2'd1;
      end
      case (state)
        RUN:     if (hazard) state <= STALL;
        STALL:   if (age == 2'd0 || (age == 2'd1 && advance)) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.reg_write   = bundle_q.reg_write;
  assign bus.operand_a   = bundle_q.operand_a;
  assign bus.operand_b   = bundle_q.operand_b;
  assign bus.load        = bundle_q.load;
  assign bus.store       = bundle_q.store;
  assign bus.branch      = bundle_q.branch;
  assign bus.jal         = bundle_q.jal;
  assign bus.jalr        = bundle_q.jalr;
  assign bus.mem_en      = bundle_q.mem_en;
  assign bus.imm_sel     = bundle_q.imm_sel;
  assign bus.mem_to_reg  = bundle_q.mem_to_reg;
  assign bus.alu_control = ALU_OP_W'(bundle_q.alu_control);
  assign bus.rs1         = bundle_q.rs1;
  assign bus.rs2         = bundle_q.rs2;
  assign bus.rd          = bundle_q.rd;
  assign bus.fun3        = bundle_q.fun3;
  assign bus.illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Self-checking bench for decode_ctrl_stage: directed steps then random traffic against a reference model.
// Build with RV32M_EN defined to check the multiply/divide decode.
module tb_decode_ctrl_stage;

  localparam int LSC = 2;
  localparam int AW  = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic        m_valid;
  logic [37:0] m_bundle;
  int          m_age;
  logic [4:0]  m_load_rd;

  decode_ctrl_stage_if #(.ALU_OP_W(AW)) bus ();

  decode_ctrl_stage #(.ALU_OP_W(AW), .LOAD_STALL_CYCLES(LSC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  // Expected bundle packed as {9 flags, imm_sel, mem_to_reg, alu, rs1, rs2, rd, fun3, illegal}.
  function automatic logic [37:0] ref_decode(input logic [31:0] i);
    logic [6:0] op, f7;
    logic [2:0] f3;
    int base, alu, imm, wb;
    logic rw, oa, ob, ld, st, br, jl, jr, bad;
    op = i[6:0];
    f7 = i[31:25];
    f3 = i[14:12];
    base = (f3 == 3'd0) ? 0 : (f3 < 3'd6) ? int'(f3) + 1 : int'(f3) + 2;
    alu = 0;
    imm = 0;
    wb  = 0;
    {rw, oa, ob, ld, st, br, jl, jr, bad} = '0;
    case (op)
      7'h33: begin
        rw = 1'b1;
        if (f7 == 7'h01) begin
`ifdef RV32M_EN
          alu = 16 + int'(f3);
`else
          bad = 1'b1;
`endif
        end else begin
          alu = base + (((f3 == 3'd0) || (f3 == 3'd5)) ? int'(i[30]) : 0);
        end
      end
      7'h13: begin
        rw  = 1'b1;
        ob  = 1'b1;
        alu = base + ((f3 == 3'd5) ? int'(i[30]) : 0);
        if ((f3 == 3'd1 || f3 == 3'd5) && !(f7 == 7'h00 || f7 == 7'h20)) bad = 1'b1;
      end
      7'h03: begin
        rw = 1'b1; ob = 1'b1; ld = 1'b1; wb = 1;
        bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      end
      7'h23: begin st = 1'b1; ob = 1'b1; imm = 1; bad = (f3 > 3'd2); end
      7'h63: begin br = 1'b1; oa = 1'b1; ob = 1'b1; imm = 2; end
      7'h6f: begin rw = 1'b1; oa = 1'b1; ob = 1'b1; jl = 1'b1; imm = 3; wb = 2; end
      7'h67: begin rw = 1'b1; ob = 1'b1; jr = 1'b1; wb = 2; end
      7'h37: begin rw = 1'b1; ob = 1'b1; imm = 4; alu = 15; end
      7'h17: begin rw = 1'b1; oa = 1'b1; ob = 1'b1; imm = 4; end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      {rw, oa, ob, ld, st, br, jl, jr} = '0;
      alu = 0;
      imm = 0;
      wb  = 0;
    end
    if (i[11:7] == 5'd0) rw = 1'b0;
    return {rw, oa, ob, ld, st, br, jl, jr, st, imm[2:0], wb[1:0], alu[4:0],
            i[19:15], i[24:20], i[11:7], f3, bad};
  endfunction

  function automatic logic uses_rs1(input logic [31:0] i);
    return !(i[6:0] inside {7'h37, 7'h17, 7'h6f});
  endfunction

  function automatic logic uses_rs2(input logic [31:0] i);
    return i[6:0] inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic logic [37:0] obs_bundle();
    return {bus.reg_write, bus.operand_a, bus.operand_b, bus.load, bus.store, bus.branch, bus.jal,
            bus.jalr, bus.mem_en, bus.imm_sel, bus.mem_to_reg, bus.alu_control, bus.rs1, bus.rs2,
            bus.rd, bus.fun3, bus.illegal};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] op, f7;
    case ($urandom_range(0, 9))
      0:       op = 7'h33;
      1:       op = 7'h13;
      2:       op = 7'h03;
      3:       op = 7'h23;
      4:       op = 7'h63;
      5:       op = 7'h6f;
      6:       op = 7'h67;
      7:       op = 7'h37;
      8:       op = 7'h17;
      default: op = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      2:       f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
            5'($urandom_range(0, 3)), op};
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left just after a rising edge; checks the cycle's outputs at the falling edge.
  task automatic apply_stimulus(input logic v, input logic [31:0] instr, input logic rdy, input logic fl);
    logic [37:0] dec;
    logic haz, adv, exp_ready, acc;
    bus.if_valid = v;
    bus.if_instr = instr;
    bus.ex_ready = rdy;
    flush        = fl;
    @(negedge clk);
    dec = ref_decode(instr);
    haz = (m_age > 0) && v && (m_load_rd != 5'd0) &&
          ((uses_rs1(instr) && instr[19:15] == m_load_rd) || (uses_rs2(instr) && instr[24:20] == m_load_rd));
    adv       = !m_valid || rdy;
    exp_ready = adv && !haz && !fl;
    check_output("if_ready", 64'(bus.if_ready), 64'(exp_ready));
    check_output("ex_valid", 64'(bus.ex_valid), 64'(m_valid));
    if (m_valid) check_output("bundle", 64'(obs_bundle()), 64'(m_bundle));
    acc = v && exp_ready;
    @(posedge clk);
    if (fl) begin
      m_valid = 1'b0;
      m_age   = 0;
    end else begin
      if (acc) begin
        m_valid  = 1'b1;
        m_bundle = dec;
      end else if (adv) begin
        m_valid = 1'b0;
      end
      if (acc && dec[34] && instr[11:7] != 5'd0) begin
        m_load_rd = instr[11:7];
        m_age     = LSC;
      end else if (adv && m_age > 0) begin
        m_age--;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_instr = '0;
    bus.ex_ready = 1'b0;
    flush        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_ex_valid", 64'(bus.ex_valid), 64'd0);
    check_output("reset_bundle", 64'(obs_bundle()), 64'd0);
    m_valid   = 1'b0;
    m_bundle  = '0;
    m_age     = 0;
    m_load_rd = '0;
    rst_n     = 1'b1;
  endtask

  initial begin
    logic [31:0] add1, sub1, srai1, lw5, add_dep, lw0, add_x0, bad_op, mul1;
    logic [37:0] snap;
    int bubbles;
    logic issued;

    add1    = enc(7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33);
    sub1    = enc(7'h20, 5'd6, 5'd5, 3'd0, 5'd4, 7'h33);
    srai1   = enc(7'h20, 5'd3, 5'd8, 3'd5, 5'd7, 7'h13);
    lw5     = enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03);
    add_dep = enc(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33);
    lw0     = enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd0, 7'h03);
    add_x0  = enc(7'h00, 5'd2, 5'd0, 3'd0, 5'd6, 7'h33);
    bad_op  = enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd3, 7'h7f);
    mul1    = enc(7'h01, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33);

    do_reset();

    // Back-to-back ALU ops at full throughput.
    apply_stimulus(1'b1, add1, 1'b1, 1'b0);
    check_output("add_valid", 64'(bus.ex_valid), 64'd1);
    check_output("add_alu", 64'(bus.alu_control), 64'd0);
    apply_stimulus(1'b1, sub1, 1'b1, 1'b0);
    check_output("sub_valid", 64'(bus.ex_valid), 64'd1);
    check_output("sub_alu", 64'(bus.alu_control), 64'd1);
    apply_stimulus(1'b1, srai1, 1'b1, 1'b0);
    check_output("srai_valid", 64'(bus.ex_valid), 64'd1);
    check_output("srai_alu", 64'(bus.alu_control), 64'd7);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);

    // Load followed by a dependent add.
    apply_stimulus(1'b1, lw5, 1'b1, 1'b0);
    check_output("lw_mem_to_reg", 64'(bus.mem_to_reg), 64'd1);
    bubbles = 0;
    issued  = 1'b0;
    for (int k = 0; k < 8 && !issued; k++) begin
      apply_stimulus(1'b1, add_dep, 1'b1, 1'b0);
      if (bus.ex_valid) issued = 1'b1;
      else bubbles++;
    end
    check_output("dep_issued", 64'(issued), 64'd1);
    check_output("load_use_bubbles", 64'(bubbles), 64'(LSC));
    check_output("dep_alu", 64'(bus.alu_control), 64'd0);

    // Load to x0 never interlocks.
    apply_stimulus(1'b1, lw0, 1'b1, 1'b0);
    check_output("lw_x0_valid", 64'(bus.ex_valid), 64'd1);
    apply_stimulus(1'b1, add_x0, 1'b1, 1'b0);
    check_output("add_x0_no_bubble", 64'(bus.ex_valid), 64'd1);

    // Backpressure holds the bundle.
    apply_stimulus(1'b1, add1, 1'b1, 1'b0);
    snap = obs_bundle();
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, sub1, 1'b0, 1'b0);
      check_output("bp_valid", 64'(bus.ex_valid), 64'd1);
      check_output("bp_stable", 64'(obs_bundle()), 64'(snap));
      check_output("bp_if_ready", 64'(bus.if_ready), 64'd0);
    end
    apply_stimulus(1'b1, sub1, 1'b1, 1'b0);
    check_output("bp_release_alu", 64'(bus.alu_control), 64'd1);
    check_output("bp_release_rd", 64'(bus.rd), 64'd4);

    // Flush during a stall.
    apply_stimulus(1'b1, lw5, 1'b1, 1'b0);
    apply_stimulus(1'b1, add_dep, 1'b1, 1'b0);
    check_output("stall_bubble", 64'(bus.ex_valid), 64'd0);
    apply_stimulus(1'b1, add_dep, 1'b1, 1'b1);
    check_output("flush_valid", 64'(bus.ex_valid), 64'd0);
    flush = 1'b0;
    #1;
    check_output("flush_if_ready", 64'(bus.if_ready), 64'd1);
    apply_stimulus(1'b1, add_dep, 1'b1, 1'b0);
    check_output("post_flush_issue", 64'(bus.ex_valid), 64'd1);
    check_output("post_flush_rd", 64'(bus.rd), 64'd6);

    // Illegal encodings.
    apply_stimulus(1'b1, bad_op, 1'b1, 1'b0);
    check_output("badop_illegal", 64'(bus.illegal), 64'd1);
    check_output("badop_reg_write", 64'(bus.reg_write), 64'd0);
    check_output("badop_valid", 64'(bus.ex_valid), 64'd1);
    apply_stimulus(1'b1, mul1, 1'b1, 1'b0);
`ifdef RV32M_EN
    check_output("mul_alu", 64'(bus.alu_control), 64'd16);
    check_output("mul_illegal", 64'(bus.illegal), 64'd0);
`else
    check_output("mul_illegal", 64'(bus.illegal), 64'd1);
    check_output("mul_reg_write", 64'(bus.reg_write), 64'd0);
`endif

    // Reset in the middle of a stall drops the held instruction.
    apply_stimulus(1'b1, lw5, 1'b1, 1'b0);
    apply_stimulus(1'b1, add_dep, 1'b1, 1'b0);
    do_reset();
    apply_stimulus(1'b1, add_dep, 1'b1, 1'b0);
    check_output("post_reset_issue", 64'(bus.ex_valid), 64'd1);

    // Random traffic with backpressure, flushes and frequent register overlap.
    for (int c = 0; c < 400; c++) begin
      apply_stimulus($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
                     $urandom_range(0, 31) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
